// File: rtl/fetch_decode.sv
// fetch_decode: walks a colon word's opcode bytes, assembles inline literals and
// hands one opcode per handshake to the execution unit.
module fetch_decode #(
    parameter int          DSZ     = 32,
    parameter int          ASZ     = 17,
    parameter logic [7:0]  LIT_OP  = 8'h02,
    parameter logic [7:0]  HALT_OP = 8'hFF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [ASZ-1:0] ip0,
    output logic           mem_rd,
    output logic [ASZ-1:0] mem_addr,
    input  logic [7:0]     mem_q,
    output logic [7:0]     op,
    output logic [ASZ-1:0] op_ip,
    output logic [DSZ-1:0] lit,
    output logic           op_valid,
    input  logic           op_ready,
    input  logic           jmp_en,
    input  logic [ASZ-1:0] jmp_addr,
    output logic           busy
);
    localparam int NB = DSZ / 8;
    localparam int CW = NB > 1 ? $clog2(NB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

    typedef enum logic [2:0] {IDLE, OP, DEC, LIT, ISSUE} state_t;

    state_t         state_q, state_d;
    logic [ASZ-1:0] ip_q, ip_d, op_ip_q, op_ip_d;
    logic [7:0]     op_q, op_d;
    logic [DSZ-1:0] lit_q, lit_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ip_q    <= '0;
            op_ip_q <= '0;
            op_q    <= '0;
            lit_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            op_ip_q <= op_ip_d;
            op_q    <= op_d;
            lit_q   <= lit_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ip_d     = ip_q;
        op_ip_d  = op_ip_q;
        op_d     = op_q;
        lit_d    = lit_q;
        cnt_d    = cnt_q;
        mem_rd   = 1'b0;
        mem_addr = '0;
        unique case (state_q)
            IDLE: if (start) begin
                ip_d    = ip0;
                state_d = OP;
            end
            OP: begin
                mem_rd   = 1'b1;
                mem_addr = ip_q;
                op_ip_d  = ip_q;
                ip_d     = ip_q + ASZ'(1);
                state_d  = DEC;
            end
            DEC: begin
                op_d  = mem_q;
                lit_d = '0;
                if (mem_q == LIT_OP) begin
                    mem_rd   = 1'b1;
                    mem_addr = ip_q;
                    ip_d     = ip_q + ASZ'(1);
                    cnt_d    = '0;
                    state_d  = LIT;
                end else begin
                    state_d = ISSUE;
                end
            end
            LIT: begin
                // each byte lands one cycle after its read; the last one issues no further read
                lit_d[8*cnt_q +: 8] = mem_q;
                if (cnt_q == CNT_LAST) begin
                    state_d = ISSUE;
                end else begin
                    mem_rd   = 1'b1;
                    mem_addr = ip_q;
                    ip_d     = ip_q + ASZ'(1);
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            ISSUE: if (op_ready) begin
                state_d = op_q == HALT_OP ? IDLE : OP;
                ip_d    = (op_q != HALT_OP && jmp_en) ? jmp_addr : ip_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign op       = op_q;
    assign op_ip    = op_ip_q;
    assign lit      = lit_q;
    assign op_valid = state_q == ISSUE;
    assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: random and directed opcode programs; a program-walking model
// fills a scoreboard that a negedge monitor drains on each handshake.
module tb_fetch_decode;
    localparam int ASZ = 17;
    localparam int DSZ = 32;
    localparam int NB = DSZ / 8;
    localparam int MAXOPS = 64;
    localparam logic [7:0] LIT_OP = 8'h02;
    localparam logic [7:0] HALT_OP = 8'hFF;

    typedef struct {
        logic [7:0]     op;
        logic [ASZ-1:0] ip;
        logic [DSZ-1:0] lit;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst, start, op_ready, jmp_en;
    logic [ASZ-1:0] ip0, jmp_addr;
    logic           mem_rd, op_valid, busy;
    logic [ASZ-1:0] mem_addr, op_ip;
    logic [7:0]     mem_q, op;
    logic [DSZ-1:0] lit;

    logic [7:0]     mem [0:(1<<ASZ)-1];
    bit             used [0:(1<<ASZ)-1];
    exp_t           exp_q[$];
    bit             exp_lit [MAXOPS];
    int             n_exp;
    bit             plan_jmp [MAXOPS];
    logic [ASZ-1:0] plan_tgt [MAXOPS];
    int             plan_stall [MAXOPS];
    int             total = 0;
    int             bad = 0;

    fetch_decode #(.DSZ(DSZ), .ASZ(ASZ), .LIT_OP(LIT_OP), .HALT_OP(HALT_OP)) dut (
        .clk(clk), .rst(rst), .start(start), .ip0(ip0),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q),
        .op(op), .op_ip(op_ip), .lit(lit), .op_valid(op_valid), .op_ready(op_ready),
        .jmp_en(jmp_en), .jmp_addr(jmp_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_q <= mem_rd ? mem[mem_addr] : 8'($urandom);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (op_valid) begin
                if (exp_q.size() == 0) chk("extra_op", 64'(op_valid), 64'(0));
                else begin
                    chk("op", 64'(op), 64'(exp_q[0].op));
                    chk("op_ip", 64'(op_ip), 64'(exp_q[0].ip));
                    chk("lit", 64'(lit), 64'(exp_q[0].lit));
                    if (op_ready) void'(exp_q.pop_front());
                end
            end
            if (!busy || op_valid) chk("no_read", 64'({mem_rd, mem_addr}), 64'(0));
        end
    end

    task automatic chk_zero(input string nm);
        chk(nm, 64'({op, op_ip, lit}), 64'(0));
        chk(nm, 64'({mem_rd, mem_addr, op_valid, busy}), 64'(0));
    endtask

    task automatic junk();
        op_ready = 1'($urandom);
        jmp_en   = 1'($urandom);
        jmp_addr = ASZ'($urandom);
        start    = 1'($urandom);
        ip0      = ASZ'($urandom);
    endtask

    task automatic clr_plan();
        for (int i = 0; i < MAXOPS; i++) begin
            plan_jmp[i]   = 1'b0;
            plan_tgt[i]   = '0;
            plan_stall[i] = 0;
        end
    endtask

    // Walk the program as the execution unit sees it: opcode, optional
    // little-endian literal, then fall through or take the planned jump.
    task automatic walk(input logic [ASZ-1:0] s);
        logic [ASZ-1:0] ip, a;
        exp_t e;
        ip = s;
        n_exp = 0;
        for (int i = 0; i < MAXOPS; i++) begin
            e.op = mem[ip];
            e.ip = ip;
            e.lit = '0;
            if (e.op == LIT_OP)
                for (int b = 0; b < NB; b++) begin
                    a = ip + ASZ'(1 + b);
                    e.lit = e.lit | (DSZ'(mem[a]) << (8 * b));
                end
            exp_q.push_back(e);
            exp_lit[i] = e.op == LIT_OP;
            n_exp++;
            if (e.op == HALT_OP) break;
            ip = plan_jmp[i] ? plan_tgt[i] : ip + ASZ'(e.op == LIT_OP ? 1 + NB : 1);
        end
    endtask

    function automatic bit is_free(input logic [ASZ-1:0] t);
        logic [ASZ-1:0] a;
        for (int k = 0; k <= NB; k++) begin
            a = t + ASZ'(k);
            if (used[a]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [ASZ-1:0] pick_free();
        logic [ASZ-1:0] t = '0;
        for (int k = 0; k < 1000; k++) begin
            t = ASZ'($urandom);
            if (is_free(t)) return t;
        end
        return t;
    endfunction

    function automatic logic [7:0] plain_byte();
        logic [7:0] b;
        do b = 8'($urandom); while (b == LIT_OP || b == HALT_OP);
        return b;
    endfunction

    task automatic gen_random(input int n, output logic [ASZ-1:0] s);
        logic [ASZ-1:0] ip, t, a;
        bit is_lit, j;
        int len;
        for (int k = 0; k < (1 << ASZ); k++) used[k] = 1'b0;
        ip = pick_free();
        s = ip;
        for (int i = 0; i < n; i++) begin
            is_lit = (i < n - 1) && ($urandom_range(0, 2) == 0);
            len = is_lit ? NB + 1 : 1;
            mem[ip] = (i == n - 1) ? HALT_OP : is_lit ? LIT_OP : plain_byte();
            used[ip] = 1'b1;
            for (int b = 1; b < len; b++) begin
                a = ip + ASZ'(b);
                mem[a] = ($urandom_range(0, 4) == 0) ? HALT_OP : 8'($urandom);
                used[a] = 1'b1;
            end
            t = ip + ASZ'(len);
            j = ($urandom_range(0, 3) == 0) || !is_free(t);
            if (j) t = pick_free();
            plan_jmp[i]   = j;
            plan_tgt[i]   = t;
            plan_stall[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            ip = t;
        end
    endtask

    task automatic run_prog(input logic [ASZ-1:0] s);
        int lat;
        walk(s);
        ip0 = s;
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < n_exp; i++) begin
            lat = 0;
            while (!op_valid && lat < 40) begin
                junk();
                @(posedge clk); #1;
                lat++;
            end
            chk("latency", 64'(lat), 64'(exp_lit[i] ? 2 + NB : 2));
            if (!op_valid) begin
                {start, op_ready, jmp_en} = '0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            for (int k = 0; k < plan_stall[i]; k++) begin
                junk();
                op_ready = 1'b0;
                @(posedge clk); #1;
            end
            junk();
            op_ready = 1'b1;
            jmp_en   = plan_jmp[i];
            jmp_addr = plan_tgt[i];
            if (i == n_exp - 1) start = 1'b0;
            @(posedge clk); #1;
        end
        {start, op_ready, jmp_en} = '0;
        chk("halt_idle", 64'(busy), 64'(0));
        chk("sb_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [ASZ-1:0] s;
        {rst, start, op_ready, jmp_en} = '0;
        ip0 = '0;
        jmp_addr = '0;
        for (int a = 0; a < (1 << ASZ); a++) mem[a] = 8'($urandom);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        clr_plan();
        mem[17'h100] = 8'h10;
        mem[17'h101] = HALT_OP;
        run_prog(17'h100);

        clr_plan();
        mem[17'h200] = LIT_OP;
        mem[17'h201] = 8'h78;
        mem[17'h202] = 8'h56;
        mem[17'h203] = 8'h34;
        mem[17'h204] = 8'h12;
        mem[17'h205] = HALT_OP;
        plan_stall[0] = 5;
        run_prog(17'h200);

        clr_plan();
        mem[17'h180] = 8'h11;
        mem[17'h300] = 8'h22;
        mem[17'h301] = HALT_OP;
        plan_jmp[0] = 1'b1;
        plan_tgt[0] = 17'h300;
        run_prog(17'h180);

        clr_plan();
        mem[17'h1FFFE] = LIT_OP;
        mem[17'h1FFFF] = 8'hA1;
        mem[17'h00000] = 8'hB2;
        mem[17'h00001] = HALT_OP;
        mem[17'h00002] = 8'hD4;
        mem[17'h00003] = HALT_OP;
        run_prog(17'h1FFFE);

        ip0 = 17'h200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        jmp_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        jmp_en = 1'b0;
        chk_zero("mid_lit_reset");
        clr_plan();
        run_prog(17'h100);

        for (int r = 0; r < 8; r++) begin
            clr_plan();
            gen_random($urandom_range(4, 20), s);
            run_prog(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
